// File: rtl/debounce_pkg.sv
// Purpose: shared types and constants for the debounce block (FSM states, default qualification length).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package debounce_pkg;

  // Default number of consecutive equal samples needed to accept a new level.
  localparam int STABLE_CYCLES_DEFAULT = 4;

  // Debounce FSM: two settled states and two qualification states.
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    PEND_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    PEND_LOW    = 2'd3
  } state_t;

  // Qualification counter width; one spare bit above clog2 keeps the compare simple.
  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles) + 1;
  endfunction

endpackage

// File: rtl/debounce_timer.sv
// Purpose: qualification counter for the debouncer with clear, increment and terminal-count flag.
// Latency: count updates on the clock edge after clr/inc; tc is combinational from the count register.
// Backpressure: none; the counter follows clr/inc every cycle.
module debounce_timer #(
  parameter int STABLE_CYCLES = debounce_pkg::STABLE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic tc
);
  import debounce_pkg::*;

  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic [CW-1:0] count;

  // Counter register: clear wins over increment, so it never runs past LAST.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + ONE;
    end
  end

  // Terminal count: this sample is the last one needed to complete qualification.
  assign tc = (count == LAST);

endmodule

// File: rtl/debounce.sv
// Purpose: debounce a pre-synchronised input; registered level plus one-cycle rise/fall pulses.
// Latency: a new input value held for STABLE_CYCLES sampling edges appears on level at the last of them.
// Backpressure: none; optional press counter enabled by macro DEBOUNCE_PRESS_COUNT_EN.
module debounce #(
  parameter int STABLE_CYCLES = debounce_pkg::STABLE_CYCLES_DEFAULT,
  parameter int PRESS_W       = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in,
  output logic               level,
  output logic               rise,
  output logic               fall
`ifdef DEBOUNCE_PRESS_COUNT_EN
  ,
  output logic [PRESS_W-1:0] press_count
`endif
);
  import debounce_pkg::*;

  // Reject illegal configurations at elaboration time.
  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 65535 || PRESS_W < 1) begin : g_param_check
    $error("debounce: STABLE_CYCLES must be 2..65535 and PRESS_W >= 1");
  end

  state_t state;
  logic   tmr_clr;
  logic   tmr_inc;
  logic   tmr_tc;
  logic   rise_evt;
  logic   fall_evt;

  debounce_timer #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .clr  (tmr_clr),
    .inc  (tmr_inc),
    .tc   (tmr_tc)
  );

  // Timer control and completion decode: count while the input disagrees with the settled level.
  always_comb begin
    tmr_clr  = 1'b1;
    tmr_inc  = 1'b0;
    rise_evt = 1'b0;
    fall_evt = 1'b0;
    case (state)
      STABLE_LOW: begin
        if (in) begin
          tmr_clr = 1'b0;
          tmr_inc = 1'b1;
        end
      end
      PEND_HIGH: begin
        if (in && !tmr_tc) begin
          tmr_clr = 1'b0;
          tmr_inc = 1'b1;
        end
        rise_evt = in && tmr_tc;
      end
      STABLE_HIGH: begin
        if (!in) begin
          tmr_clr = 1'b0;
          tmr_inc = 1'b1;
        end
      end
      PEND_LOW: begin
        if (!in && !tmr_tc) begin
          tmr_clr = 1'b0;
          tmr_inc = 1'b1;
        end
        fall_evt = !in && tmr_tc;
      end
      default: begin
        tmr_clr = 1'b1;
      end
    endcase
  end

  // FSM with registered level and single-cycle edge pulses; a pending change is dropped on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= STABLE_LOW;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        STABLE_LOW: begin
          if (in) state <= PEND_HIGH;
        end
        PEND_HIGH: begin
          if (!in) begin
            state <= STABLE_LOW;
          end else if (rise_evt) begin
            state <= STABLE_HIGH;
            level <= 1'b1;
            rise  <= 1'b1;
          end
        end
        STABLE_HIGH: begin
          if (!in) state <= PEND_LOW;
        end
        PEND_LOW: begin
          if (in) begin
            state <= STABLE_HIGH;
          end else if (fall_evt) begin
            state <= STABLE_LOW;
            level <= 1'b0;
            fall  <= 1'b1;
          end
        end
        default: begin
          state <= STABLE_LOW;
          level <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEBOUNCE_PRESS_COUNT_EN
  // Press counter: advances on the same edge that raises rise, wrapping naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      press_count <= '0;
    end else if (rise_evt) begin
      press_count <= press_count + PRESS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_debounce.sv
// Purpose: self-checking bench for debounce with a run-length reference model and directed scenarios.
// Latency: checks every cycle half a clock after the sampling edge.
// Backpressure: n/a.
module tb_debounce;
  localparam int SC = 4;
  localparam int PW = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in    = 1'b0;
  logic level;
  logic rise;
  logic fall;
`ifdef DEBOUNCE_PRESS_COUNT_EN
  logic [PW-1:0] press_count;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: level flips once the input has disagreed with it for SC samples in a row.
  bit m_level = 1'b0;
  bit m_rise  = 1'b0;
  bit m_fall  = 1'b0;
  int m_run   = 0;
  int m_press = 0;

  always #5 clock = ~clock;

  debounce #(
    .STABLE_CYCLES(SC),
    .PRESS_W      (PW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in   (in),
    .level(level),
    .rise (rise),
    .fall (fall)
`ifdef DEBOUNCE_PRESS_COUNT_EN
    ,
    .press_count(press_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Apply one sample, advance the model across the edge, compare on the falling edge.
  task automatic step(input logic r, input logic i);
    reset = r;
    in    = i;
    @(posedge clock);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (r) begin
      m_level = 1'b0;
      m_run   = 0;
      m_press = 0;
    end else if (i != m_level) begin
      m_run++;
      if (m_run == SC) begin
        m_level = i;
        m_run   = 0;
        if (i) begin
          m_rise  = 1'b1;
          m_press = (m_press + 1) % (1 << PW);
        end else begin
          m_fall = 1'b1;
        end
      end
    end else begin
      m_run = 0;
    end
    @(negedge clock);
    chk("level", level, m_level);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("rise_and_fall", rise & fall, 0);
`ifdef DEBOUNCE_PRESS_COUNT_EN
    chk("press_count", press_count, m_press);
`endif
  endtask

  initial begin
    logic v;
    int   len;
    bit   r;
    int   exp_seq[5];
    exp_seq = '{1, 2, 3, 0, 1};

    // Reset state
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("rst_level", level, 0);
    chk("rst_rise", rise, 0);
    chk("rst_fall", fall, 0);
`ifdef DEBOUNCE_PRESS_COUNT_EN
    chk("rst_press", press_count, 0);
`endif

    // Held high after reset: rise and level on the 4th edge, rise gone on the 5th
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b1);
      chk("hold_hi_rise", rise, (k == 4) ? 1 : 0);
      chk("hold_hi_level", level, (k >= 4) ? 1 : 0);
      chk("model_rise", m_rise, (k == 4) ? 1 : 0);
    end

    // Held low from level 1: single fall on the 4th edge
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b0);
      chk("hold_lo_fall", fall, (k == 4) ? 1 : 0);
      chk("hold_lo_level", level, (k < 4) ? 1 : 0);
      chk("model_level", m_level, (k < 4) ? 1 : 0);
    end

    // Three-sample glitch high: nothing changes
    for (int k = 0; k < 8; k++) begin
      step(1'b0, (k < 3) ? 1'b1 : 1'b0);
      chk("glitch_level", level, 0);
      chk("glitch_rise", rise, 0);
      chk("glitch_fall", fall, 0);
    end

    // Reset during pending high restarts qualification from release
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("rst_pend_level", level, 0);
    chk("rst_pend_rise", rise, 0);
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b1);
      chk("post_rst_rise", rise, (k == 4) ? 1 : 0);
      chk("post_rst_level", level, (k >= 4) ? 1 : 0);
    end

    // Reset during pending low: level drops, no fall pulse
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("rst_pend_lo_level", level, 0);
    chk("rst_pend_lo_fall", fall, 0);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0);
      chk("after_rst_lo_fall", fall, 0);
      chk("after_rst_lo_rise", rise, 0);
    end

    // Alternating input for 100 cycles
    for (int k = 0; k < 100; k++) begin
      step(1'b0, (k % 2 == 0) ? 1'b1 : 1'b0);
      chk("alt_level", level, 0);
      chk("alt_rise", rise, 0);
      chk("alt_fall", fall, 0);
    end

`ifdef DEBOUNCE_PRESS_COUNT_EN
    // Five qualified presses with a 2-bit counter: 1,2,3,0,1
    step(1'b1, 1'b0);
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < SC; k++) step(1'b0, 1'b1);
      chk("press_seq", press_count, exp_seq[p]);
      for (int k = 0; k < SC + 1; k++) step(1'b0, 1'b0);
    end
`else
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < SC; k++) step(1'b0, 1'b1);
      chk("press_rise", rise, 1);
      for (int k = 0; k < SC + 1; k++) step(1'b0, 1'b0);
    end
    chk("press_seq_model", m_press, exp_seq[4]);
`endif

    // Random runs of varying length with occasional reset
    for (int n = 0; n < 400; n++) begin
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 2 * SC);
      r   = ($urandom_range(0, 29) == 0);
      for (int k = 0; k < len; k++) step(r && (k == 0), v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/debounce.md
DEBOUNCE -- requirements
Module: debounce

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, number of consecutive equal samples required before the output changes; legal range 2..65535.
REQ-002 Parameter: PRESS_W, default 8, width of the press counter.
REQ-003 Port: clock  input  1  single clock for all logic; rising edge only.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: in  input  1  input already synchronised to clock by the upstream synchroniser stage; no further metastability handling here.
REQ-006 Port: level  output  1  debounced level, registered.
REQ-007 Port: rise  output  1  one-cycle pulse, registered; asserted in the cycle level goes 0->1.
REQ-008 Port: fall  output  1  one-cycle pulse, registered; asserted in the cycle level goes 1->0.
REQ-009 Port: press_count  output  PRESS_W  count of rise events; present only with DEBOUNCE_PRESS_COUNT_EN.

Function
REQ-010 FSM states: STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW.
REQ-011 Internal counter: width clog2(STABLE_CYCLES)+1; never exceeds STABLE_CYCLES-1.
REQ-012 STABLE_LOW, in=1 -> PEND_HIGH, count=1; in=0 -> remain, count=0.
REQ-013 PEND_HIGH, in=0 -> STABLE_LOW, count=0, no pulse.
REQ-014 PEND_HIGH, in=1, count<STABLE_CYCLES-1 -> remain, count+1.
REQ-015 PEND_HIGH, in=1, count==STABLE_CYCLES-1 -> STABLE_HIGH, count=0; at this same edge level<=1 and rise<=1.
REQ-016 STABLE_HIGH/PEND_LOW: mirror of REQ-012..015 with in inverted; completion sets level<=0 and fall<=1.
REQ-017 Latency: in held at a new value from edge N is reflected on level after edge N+STABLE_CYCLES-1, i.e. exactly STABLE_CYCLES sampling edges.
REQ-018 A glitch lasting fewer than STABLE_CYCLES samples leaves level unchanged and asserts no pulse.
REQ-019 rise and fall are deasserted in every cycle other than the completion cycle, and are never asserted together.
REQ-020 level equals 1 exactly in STABLE_HIGH and PEND_LOW.

Reset
REQ-021 reset has priority over in; it is sampled only on the rising edge of clock.
REQ-022 After reset: state STABLE_LOW, count 0, level 0, rise 0, fall 0, press_count 0.
REQ-023 Reset asserted during PEND_HIGH or PEND_LOW discards the pending transition; no pulse is emitted.
REQ-024 If in=1 when reset releases, a full STABLE_CYCLES qualification is required before rise.

Configuration
REQ-025 Macro DEBOUNCE_PRESS_COUNT_EN defined: press_count increments by 1 in the same edge rise is set, wrapping from 2^PRESS_W-1 to 0.
REQ-026 Macro undefined: press_count port and its register are absent; all other behaviour is identical.

Structure
REQ-027 The FSM state enum and the STABLE_CYCLES default constant reside in the shared package debounce_pkg.
REQ-028 The qualification counter (clear, increment, terminal-count flag) is a sub-module, debounce_timer; the FSM and outputs stay in debounce.

Verification (STABLE_CYCLES=4)
REQ-029 Reset, then in=1 held -> rise=1 and level=1 on the 4th edge after release; rise=0 on the 5th.
REQ-030 in=1 for 3 cycles, then 0 -> level stays 0, no rise, no fall.
REQ-031 From level=1, in=0 held -> fall pulses once on the 4th edge and level=0.
REQ-032 in=1 held for 2 cycles, reset pulsed for 1 cycle, in still 1 -> no rise until 4 edges after reset release.
REQ-033 With DEBOUNCE_PRESS_COUNT_EN and PRESS_W=2: 5 qualified presses -> press_count sequence 1,2,3,0,1.
REQ-034 Alternating in every cycle for 100 cycles -> level constant 0, rise and fall never asserted.
